// File: rtl/sweep_capture_engine_if.sv
// Capture stream carrying (vector, response) records from the sweep engine to a consumer.
interface sweep_capture_engine_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 1
);
  logic             cap_valid;
  logic             cap_ready;
  logic [IN_W-1:0]  cap_vec;
  logic [OUT_W-1:0] cap_resp;

  modport master (output cap_valid, output cap_vec, output cap_resp, input cap_ready);
  modport slave  (input cap_valid, input cap_vec, input cap_resp, output cap_ready);
endinterface

// File: rtl/sweep_capture_engine.sv
// Exhaustive input sweep (binary or Gray order) with settle delay, record stream and 16-bit MISR.
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | dut_in applied, settle down-counter running
// EMIT  | record presented on capture stream until accepted
// DONE  | sweep complete, results frozen until next start
module sweep_capture_engine #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  sweep_capture_engine_if.master cap,
  output logic                  busy,
  output logic                  done,
  output logic [IN_W:0]         vec_count,
  output logic [15:0]           signature
);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

  localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);
  localparam logic [IN_W:0] LAST      = (IN_W + 1)'((1 << IN_W) - 1);

  state_t           state_q, state_d;
  logic [IN_W:0]    count_q, count_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             mode_q, mode_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [IN_W-1:0]  cap_vec_q, cap_vec_d;
  logic [OUT_W-1:0] cap_resp_q, cap_resp_d;
  logic [IN_W:0]    vec_count_q, vec_count_d;
  logic [15:0]      sig_q, sig_d;

  function automatic logic [IN_W-1:0] map_vec(input logic [IN_W:0] c, input logic m);
    return IN_W'(m ? (c ^ (c >> 1)) : c);
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [OUT_W-1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'(r);
  endfunction

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      settle_q    <= '0;
      mode_q      <= 1'b0;
      dut_in_q    <= '0;
      cap_vec_q   <= '0;
      cap_resp_q  <= '0;
      vec_count_q <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      mode_q      <= mode_d;
      dut_in_q    <= dut_in_d;
      cap_vec_q   <= cap_vec_d;
      cap_resp_q  <= cap_resp_d;
      vec_count_q <= vec_count_d;
      sig_q       <= sig_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    settle_d    = settle_q;
    mode_d      = mode_q;
    dut_in_d    = dut_in_q;
    cap_vec_d   = cap_vec_q;
    cap_resp_d  = cap_resp_q;
    vec_count_d = vec_count_q;
    sig_d       = sig_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRIVE;
          count_d     = '0;
          settle_d    = SETTLE_LD;
          mode_d      = mode;
          dut_in_d    = '0;
          vec_count_d = '0;
          sig_d       = '0;
        end
      end
      DRIVE: begin
        if (settle_q == '0) begin
          state_d    = EMIT;
          cap_vec_d  = dut_in_q;
          cap_resp_d = dut_out;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      EMIT: begin
        if (cap.cap_ready) begin
          vec_count_d = vec_count_q + 1'b1;
          sig_d       = misr(sig_q, cap_resp_q);
          if (count_q == LAST) begin
            state_d = DONE;
          end else begin
            // Next vector is launched on the same edge as the handshake.
            state_d  = DRIVE;
            count_d  = count_q + 1'b1;
            dut_in_d = map_vec(count_q + 1'b1, mode_q);
            settle_d = SETTLE_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in        = dut_in_q;
  assign cap.cap_valid = (state_q == EMIT);
  assign cap.cap_vec   = cap_vec_q;
  assign cap.cap_resp  = cap_resp_q;
  assign busy          = (state_q == DRIVE) || (state_q == EMIT);
  assign done          = (state_q == DONE);
  assign vec_count     = vec_count_q;
  assign signature     = sig_q;

endmodule

// File: tb/tb_sweep_capture_engine.sv
// Directed bench: binary/Gray sweeps against a record table, backpressure, settle latency, control hazards.
module tb_sweep_capture_engine;

  logic CK = 1'b0;
  logic reset;
  always #5 CK = ~CK;

  // u0: IN_W=4, OUT_W=1, SETTLE=1, DUT = XOR-reduce
  logic       start0, mode0, rdy0;
  logic [3:0] din0;
  logic       dout0;
  logic       busy0, done0;
  logic [4:0] vc0;
  logic [15:0] sig0;
  sweep_capture_engine_if #(.IN_W(4), .OUT_W(1)) cap0 ();
  assign dout0 = ^din0;
  assign cap0.cap_ready = rdy0;

  sweep_capture_engine #(.IN_W(4), .OUT_W(1), .SETTLE(1)) u0 (
    .CK(CK), .reset(reset), .start(start0), .mode(mode0),
    .dut_in(din0), .dut_out(dout0), .cap(cap0),
    .busy(busy0), .done(done0), .vec_count(vc0), .signature(sig0));

  // u1: null DUT, SETTLE=3
  logic       start1, mode1, rdy1;
  logic [3:0] din1;
  logic       dout1;
  logic       busy1, done1;
  logic [4:0] vc1;
  logic [15:0] sig1;
  sweep_capture_engine_if #(.IN_W(4), .OUT_W(1)) cap1 ();
  assign dout1 = 1'b0;
  assign cap1.cap_ready = rdy1;

  sweep_capture_engine #(.IN_W(4), .OUT_W(1), .SETTLE(3)) u1 (
    .CK(CK), .reset(reset), .start(start1), .mode(mode1),
    .dut_in(din1), .dut_out(dout1), .cap(cap1),
    .busy(busy1), .done(done1), .vec_count(vc1), .signature(sig1));

  typedef struct {
    logic       mode;
    logic [3:0] vec;
    logic       resp;
  } rec_t;

  rec_t tab[32];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
  endfunction

  // One full sweep on u0; bp stalls vector 5 for 5 cycles, hz pokes start/mode mid-sweep.
  task automatic run0(input logic m, input bit bp, input bit hz);
    int n, cyc, bpc;
    logic [15:0] seen, sig_m;
    logic [3:0]  prev;
    bit got_done;
    n = 0; bpc = 0; seen = '0; sig_m = '0; prev = '0; got_done = 0;
    mode0 = m; start0 = 1'b1; rdy0 = 1'b1;
    @(posedge CK); #1;
    start0 = 1'b0; cyc = 1;
    chk("start_clear", {busy0, done0, vc0, sig0, din0, cap0.cap_valid},
        {1'b1, 1'b0, 5'd0, 16'h0000, 4'h0, 1'b0});
    while (!got_done && cyc < 200) begin
      if (hz) begin
        start0 = (cyc == 4 || cyc == 11 || cyc == 20);
        mode0  = m ^ cyc[0];
      end
      if (bp && cap0.cap_valid && cap0.cap_vec == 4'd5 && bpc < 5) begin
        rdy0 = 1'b0;
        bpc++;
        chk("stall_hold", {cap0.cap_valid, din0, vc0}, {1'b1, 4'd5, 5'd5});
      end else begin
        rdy0 = 1'b1;
      end
      if (cap0.cap_valid && rdy0) begin
        if (n < 16) begin
          chk("rec_vec", cap0.cap_vec, tab[n + (m ? 16 : 0)].vec);
          chk("rec_resp", cap0.cap_resp, tab[n + (m ? 16 : 0)].resp);
        end
        chk("rec_din", din0, cap0.cap_vec);
        chk("rec_dup", seen[cap0.cap_vec], 1'b0);
        if (m && n > 0) chk("gray_onebit", $countones(cap0.cap_vec ^ prev), 1);
        seen[cap0.cap_vec] = 1'b1;
        sig_m = misr(sig_m, {15'd0, cap0.cap_resp});
        prev = cap0.cap_vec;
        n++;
      end
      @(posedge CK); #1;
      cyc++;
      if (done0) got_done = 1;
    end
    start0 = 1'b0; rdy0 = 1'b1; mode0 = m;
    chk("done_latency", cyc, bp ? 38 : 33);
    chk("rec_total", n, 16);
    chk("rec_cover", seen, 16'hFFFF);
    chk("done_state", {busy0, done0, cap0.cap_valid, vc0}, {1'b0, 1'b1, 1'b0, 5'd16});
    chk("signature", sig0, sig_m);
    chk("last_din", din0, m ? 4'h8 : 4'hF);
    if (bp) chk("stall_cycles", bpc, 5);
  endtask

  initial begin
    int k, cyc, drv, n1;
    logic pv;
    logic [15:0] bresp, gresp;
    logic [63:0] gord;

    bresp = 16'b0110100110010110;
    gresp = 16'b0101010101010101;
    gord  = 64'h01326754CDFEAB98;
    for (int i = 0; i < 16; i++) begin
      tab[i]      = '{1'b0, 4'(i), bresp[15-i]};
      tab[16 + i] = '{1'b1, gord[63-4*i -: 4], gresp[15-i]};
    end

    reset = 1'b1; start0 = 1'b0; mode0 = 1'b0; rdy0 = 1'b1;
    start1 = 1'b0; mode1 = 1'b0; rdy1 = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    reset = 1'b0;
    chk("reset_u0", {din0, cap0.cap_valid, cap0.cap_vec, cap0.cap_resp, busy0, done0, vc0, sig0}, '0);
    chk("reset_u1", {din1, cap1.cap_valid, busy1, done1, vc1, sig1}, '0);

    run0(1'b0, 0, 0);  // binary
    run0(1'b1, 0, 0);  // Gray, restarted from DONE
    run0(1'b0, 1, 0);  // backpressure on vec 5
    run0(1'b1, 0, 1);  // start/mode pokes while busy

    // Reset while vector 9 is on the stream
    mode0 = 1'b0; start0 = 1'b1;
    @(posedge CK); #1;
    start0 = 1'b0; k = 0;
    while (!(cap0.cap_valid && cap0.cap_vec == 4'd9) && k < 100) begin
      @(posedge CK); #1;
      k++;
    end
    chk("reach_vec9", cap0.cap_vec, 4'd9);
    reset = 1'b1;
    @(posedge CK); #1;
    reset = 1'b0;
    chk("mid_reset", {din0, cap0.cap_valid, cap0.cap_vec, cap0.cap_resp, busy0, done0, vc0, sig0}, '0);
    repeat (3) @(posedge CK);
    #1;
    chk("stay_idle", {busy0, done0, cap0.cap_valid}, 3'b000);
    run0(1'b0, 0, 0);

    // Null DUT with SETTLE=3
    start1 = 1'b1;
    @(posedge CK); #1;
    start1 = 1'b0; cyc = 1; drv = 1; pv = 1'b0; n1 = 0;
    while (!done1 && cyc < 400) begin
      if (cap1.cap_valid && !pv) chk("settle_lat", cyc - drv, 3);
      pv = cap1.cap_valid;
      if (cap1.cap_valid) begin
        drv = cyc + 1;
        n1++;
      end
      @(posedge CK); #1;
      cyc++;
    end
    chk("null_latency", cyc, 65);
    chk("null_count", {n1[4:0], vc1}, {5'd16, 5'd16});
    chk("null_sig", sig1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
